// File: rtl/pc_sequencer_if.sv
// Fetch-side handshake between the PC sequencer (master) and the fetch stage (slave).
// The sequencer offers pc/pc_valid; the fetch stage answers with fetch_ready and stall.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            fetch_ready;
  logic            pc_valid;
  logic [XLEN-1:0] pc;

  modport master (
    input  stall,
    input  fetch_ready,
    output pc_valid,
    output pc
  );

  modport slave (
    output stall,
    output fetch_ready,
    input  pc_valid,
    input  pc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-address generator: BOOT/RUN/HALT sequencing, trap/redirect priority, misalignment faults.
// Optional macro PC_SEQ_CEXT_EN adds is_compressed_i (2-byte steps, halfword-aligned redirects).
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0004,
  parameter int              PC_STEP      = 4,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pc_sequencer_if.master   fetch,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_target_i,
  input  logic             trap_valid_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
`ifdef PC_SEQ_CEXT_EN
  input  logic             is_compressed_i,
`endif
  output logic             misalign_fault_o,
  output logic [XLEN-1:0]  fault_addr_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] issue_count_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic [XLEN-1:0]  fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             fire;
  logic             misaligned;
  logic [XLEN-1:0]  step;
  logic [XLEN-1:0]  redirect_pc;

  assign fire = pc_valid_q & fetch.fetch_ready & ~fetch.stall;

`ifdef PC_SEQ_CEXT_EN
  assign misaligned = redirect_target_i[0];
  assign step       = is_compressed_i ? XLEN'(2) : XLEN'(PC_STEP);
`else
  assign misaligned = |redirect_target_i[1:0];
  assign step       = XLEN'(PC_STEP);
`endif

  // A rejected redirect lands on the trap vector instead of the bad target.
  assign redirect_pc = misaligned ? TRAP_VECTOR : redirect_target_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    halted_d     = halted_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    count_d      = fire ? count_q + CNT_W'(1) : count_q;

    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (trap_valid_i) begin
          pc_d = TRAP_VECTOR;
        end else if (redirect_valid_i) begin
          pc_d = redirect_pc;
          if (misaligned) begin
            fault_d      = 1'b1;
            fault_addr_d = redirect_target_i;
          end
        end else if (halt_req_i) begin
          state_d    = HALT;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (fire) begin
          pc_d = pc_q + step;
        end
      end
      HALT: begin
        // Resume is honoured alongside a redirect so a debugger can redirect-and-go.
        if (trap_valid_i) begin
          pc_d       = TRAP_VECTOR;
          state_d    = RUN;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end else begin
          if (redirect_valid_i) begin
            pc_d = redirect_pc;
            if (misaligned) begin
              fault_d      = 1'b1;
              fault_addr_d = redirect_target_i;
            end
          end
          if (resume_i) begin
            state_d    = RUN;
            pc_valid_d = 1'b1;
            halted_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d    = BOOT;
        pc_valid_d = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign fetch.pc         = pc_q;
  assign fetch.pc_valid   = pc_valid_q;
  assign misalign_fault_o = fault_q;
  assign fault_addr_o     = fault_addr_q;
  assign halted_o         = halted_q;
  assign issue_count_o    = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios, then randomized traffic
// compared every cycle against a behavioural model of the fetch-address rules.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h8000;
  localparam logic [31:0] TV = 32'h0004;

  logic        clk;
  logic        resetN;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        trapValid;
  logic        haltReq;
  logic        resume;
  logic        isCompressed;
  logic        misalignFault;
  logic [31:0] faultAddr;
  logic        halted;
  logic [15:0] issueCount;

  pc_sequencer_if #(.XLEN(32)) fif ();

  pc_sequencer dut (
    .clk               (clk),
    .reset_n           (resetN),
    .fetch             (fif),
    .redirect_valid_i  (redirectValid),
    .redirect_target_i (redirectTarget),
    .trap_valid_i      (trapValid),
    .halt_req_i        (haltReq),
    .resume_i          (resume),
`ifdef PC_SEQ_CEXT_EN
    .is_compressed_i   (isCompressed),
`endif
    .misalign_fault_o  (misalignFault),
    .fault_addr_o      (faultAddr),
    .halted_o          (halted),
    .issue_count_o     (issueCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference view of the sequencer: mode is "boot", "run" or "halt".
  string       mMode = "boot";
  logic [31:0] mPc = RV;
  logic        mValid = 1'b0;
  logic        mHalted = 1'b0;
  logic        mFault = 1'b0;
  logic [31:0] mFaultAddr = '0;
  longint      mFires = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit isMisaligned(input logic [31:0] target);
`ifdef PC_SEQ_CEXT_EN
    return (target % 2) != 0;
`else
    return (target % 4) != 0;
`endif
  endfunction

  task automatic takeRedirect(output bit faultNow);
    faultNow = 1'b0;
    if (isMisaligned(redirectTarget)) begin
      mPc        = TV;
      faultNow   = 1'b1;
      mFaultAddr = redirectTarget;
    end else begin
      mPc = redirectTarget;
    end
  endtask

  task automatic stepModel();
    bit fire;
    bit faultNow;
    longint stepBytes;
    fire      = mValid && fif.fetch_ready && !fif.stall;
    faultNow  = 1'b0;
`ifdef PC_SEQ_CEXT_EN
    stepBytes = isCompressed ? 2 : 4;
`else
    stepBytes = 4;
`endif
    if (!resetN) begin
      mMode = "boot"; mPc = RV; mValid = 0; mHalted = 0; mFaultAddr = 0; mFires = 0;
    end else begin
      if (fire) mFires++;
      if (mMode == "boot") begin
        mMode = "run"; mValid = 1;
      end else if (mMode == "run") begin
        if (trapValid) mPc = TV;
        else if (redirectValid) takeRedirect(faultNow);
        else if (haltReq) begin mMode = "halt"; mValid = 0; mHalted = 1; end
        else if (fire) mPc = 32'((longint'(mPc) + stepBytes) % 64'h1_0000_0000);
      end else begin
        if (trapValid) begin
          mPc = TV; mMode = "run"; mValid = 1; mHalted = 0;
        end else begin
          if (redirectValid) takeRedirect(faultNow);
          if (resume) begin mMode = "run"; mValid = 1; mHalted = 0; end
        end
      end
    end
    mFault = faultNow;
  endtask

  // One clock: advance the model with the inputs now applied, then compare all outputs.
  task automatic applyStimulus();
    stepModel();
    @(posedge clk);
    #1;
    checkOutput("pc",        64'(fif.pc),       64'(mPc));
    checkOutput("pcValid",   64'(fif.pc_valid), 64'(mValid));
    checkOutput("halted",    64'(halted),       64'(mHalted));
    checkOutput("fault",     64'(misalignFault),64'(mFault));
    checkOutput("faultAddr", 64'(faultAddr),    64'(mFaultAddr));
    checkOutput("count",     64'(issueCount),   64'(mFires % 65536));
  endtask

  initial begin
    resetN = 0; fif.stall = 0; fif.fetch_ready = 0; redirectValid = 0;
    redirectTarget = '0; trapValid = 0; haltReq = 0; resume = 0; isCompressed = 0;

    repeat (2) applyStimulus();
    checkOutput("rstPc", 64'(fif.pc), 64'h8000);
    checkOutput("rstValid", 64'(fif.pc_valid), 64'h0);
    checkOutput("rstCount", 64'(issueCount), 64'h0);

    resetN = 1; fif.fetch_ready = 1;
    applyStimulus();
    checkOutput("bootValid", 64'(fif.pc_valid), 64'h1);
    checkOutput("bootPc", 64'(fif.pc), 64'h8000);
    repeat (2) applyStimulus();
    checkOutput("twoFiresPc", 64'(fif.pc), 64'h8008);

    fif.fetch_ready = 0;
    repeat (5) applyStimulus();
    checkOutput("holdPc", 64'(fif.pc), 64'h8008);
    checkOutput("holdCount", 64'(issueCount), 64'h2);

    fif.fetch_ready = 1;
    applyStimulus();
    checkOutput("threeFiresCount", 64'(issueCount), 64'h3);
    checkOutput("threeFiresPc", 64'(fif.pc), 64'h800c);

    redirectValid = 1; redirectTarget = 32'h9000;
    applyStimulus();
    checkOutput("redirFirePc", 64'(fif.pc), 64'h9000);
    checkOutput("redirFireCount", 64'(issueCount), 64'h4);

    fif.fetch_ready = 0; redirectTarget = 32'h9002;
    applyStimulus();
`ifdef PC_SEQ_CEXT_EN
    checkOutput("halfRedirPc", 64'(fif.pc), 64'h9002);
    checkOutput("halfRedirFault", 64'(misalignFault), 64'h0);
`else
    checkOutput("misalignPc", 64'(fif.pc), 64'h4);
    checkOutput("misalignPulse", 64'(misalignFault), 64'h1);
    checkOutput("misalignAddr", 64'(faultAddr), 64'h9002);
`endif
    redirectValid = 0;
    applyStimulus();
    checkOutput("pulseEnds", 64'(misalignFault), 64'h0);

    trapValid = 1; redirectValid = 1; redirectTarget = 32'h9000;
    applyStimulus();
    checkOutput("trapWinsPc", 64'(fif.pc), 64'h4);
    checkOutput("trapNoFault", 64'(misalignFault), 64'h0);

    trapValid = 0; redirectValid = 0; haltReq = 1;
    applyStimulus();
    checkOutput("haltValid", 64'(fif.pc_valid), 64'h0);
    checkOutput("haltFlag", 64'(halted), 64'h1);

    haltReq = 0; redirectValid = 1; redirectTarget = 32'ha000;
    applyStimulus();
    checkOutput("haltRedirPc", 64'(fif.pc), 64'ha000);
    checkOutput("haltStays", 64'(halted), 64'h1);

    redirectValid = 0; resume = 1; fif.fetch_ready = 1;
    applyStimulus();
    checkOutput("resumeValid", 64'(fif.pc_valid), 64'h1);
    resume = 0;
    applyStimulus();
    checkOutput("resumeFirePc", 64'(fif.pc), 64'ha004);
    checkOutput("resumeFireCount", 64'(issueCount), 64'h5);

    fif.fetch_ready = 0; redirectValid = 1; redirectTarget = 32'hffff_fffc;
    applyStimulus();
    redirectValid = 0; fif.fetch_ready = 1;
    applyStimulus();
    checkOutput("pcWrap", 64'(fif.pc), 64'h0);

    fif.stall = 1; resetN = 0;
    applyStimulus();
    checkOutput("midRstPc", 64'(fif.pc), 64'h8000);
    checkOutput("midRstValid", 64'(fif.pc_valid), 64'h0);
    checkOutput("midRstCount", 64'(issueCount), 64'h0);

    // Randomized traffic with rare resets and occasional traps/halts.
    for (int i = 0; i < 500; i++) begin
      resetN          = ($urandom_range(0, 99) >= 2);
      fif.stall       = ($urandom_range(0, 99) < 25);
      fif.fetch_ready = ($urandom_range(0, 99) < 70);
      redirectValid   = ($urandom_range(0, 99) < 10);
      redirectTarget  = $urandom();
      trapValid       = ($urandom_range(0, 99) < 5);
      haltReq         = ($urandom_range(0, 99) < 6);
      resume          = ($urandom_range(0, 99) < 15);
      isCompressed    = $urandom_range(0, 1) == 1;
      applyStimulus();
    end

    resetN = 0; fif.stall = 0; redirectValid = 0; trapValid = 0;
    haltReq = 0; resume = 0; isCompressed = 0; fif.fetch_ready = 1;
    applyStimulus();
    resetN = 1;
    applyStimulus();
    repeat (65536) applyStimulus();
    checkOutput("countWrap", 64'(issueCount), 64'h0);
    applyStimulus();
    checkOutput("countAfterWrap", 64'(issueCount), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
